// File: rtl/xor_pkg.sv
// Shared types, mode codes and saturating-increment helper for the XOR stream accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xor_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic MODE_PASS  = 1'b0;
    localparam logic MODE_ACCUM = 1'b1;

    // Saturating increment for a counter of width w (1..32); callers cast the result back down.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/xor_out_reg.sv
// Output register slice: holds one result (data, parity, count, valid) and derives in_ready.
// Latency: result visible the cycle after load; holds while out_valid && !out_ready.
// Backpressure: in_ready drops while a result is pending and the consumer is stalled; load and release may coincide.
module xor_out_reg
    import xor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0] load_count,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Room for a new result whenever the slot is empty or is being drained this cycle.
    assign in_ready = !rst && (!out_valid || out_ready);
    assign out_sat  = (out_count == CNT_MAX);

    // Load a new result (parity computed alongside data), otherwise clear valid on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_parity <= 1'b0;
            out_count  <= '0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_data   <= load_data;
            out_parity <= ^load_data;
            out_count  <= load_count;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/xor_stream_accum.sv
// Bitwise XOR of two operand streams: per-beat (PASS) or running XOR per in_last-delimited packet (ACCUM).
// Latency: one cycle from the accepted final beat to out_valid; non-last ACCUM beats produce nothing.
// Backpressure: every beat, last or not, waits on in_ready from the output slice; 1 beat/cycle when unstalled.
module xor_stream_accum
    import xor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic             accept;
    logic [WIDTH-1:0] beat_x;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic [CNT_W-1:0] load_count;

    assign accept = in_valid && in_ready;
    assign beat_x = in_a ^ in_b;

    // Next-state, accumulator and result-load decisions; mode only matters on a packet's first beat.
    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        load       = 1'b0;
        load_data  = beat_x;
        load_count = CNT_W'(1);
        case (state)
            IDLE: begin
                if (accept) begin
                    if (mode == MODE_ACCUM && !in_last) begin
                        acc_nxt   = beat_x;
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = ACCUM;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (in_last) begin
                        load       = 1'b1;
                        load_data  = acc ^ beat_x;
                        load_count = CNT_W'(sat_inc(32'(cnt), CNT_W));
                        acc_nxt    = '0;
                        cnt_nxt    = '0;
                        state_nxt  = IDLE;
                    end else begin
                        acc_nxt = acc ^ beat_x;
                        cnt_nxt = CNT_W'(sat_inc(32'(cnt), CNT_W));
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM and packet accumulator registers; reset drops any partial packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    xor_out_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_data  (load_data),
        .load_count (load_count),
        .out_ready  (out_ready),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_parity (out_parity),
        .out_count  (out_count),
        .out_sat    (out_sat)
    );

endmodule

// File: tb/tb_xor_stream_accum.sv
// Bench for xor_stream_accum: three instances (8-bit, 8-bit with 2-bit counter, 1-bit) share one stimulus.
// Latency: model predicts the registered output one cycle after each accepted result-producing beat.
// Backpressure: out_ready is driven directly; beats are held until in_ready is seen.
module tb_xor_stream_accum;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_last, mode, out_ready;
    logic [7:0] in_a, in_b;

    logic       rdy8, vld8, par8, sat8;
    logic [7:0] dat8, cnt8;
    logic       rdy2, vld2, par2, sat2;
    logic [7:0] dat2;
    logic [1:0] cnt2;
    logic       rdy1, vld1, par1, sat1, dat1;
    logic [7:0] cnt1;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: current output slot plus the open packet's running XOR and unbounded beat count.
    bit       m_vld    = 1'b0;
    bit [7:0] m_data   = 8'h00;
    int       m_cnt    = 0;
    bit       m_in_pkt = 1'b0;
    bit [7:0] m_acc    = 8'h00;
    int       m_pcnt   = 0;
    bit       chk_en   = 1'b0;

    always #5 clk = ~clk;

    xor_stream_accum #(.WIDTH(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .mode(mode), .out_valid(vld8), .out_ready(out_ready), .out_data(dat8),
        .out_parity(par8), .out_count(cnt8), .out_sat(sat8));

    xor_stream_accum #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .mode(mode), .out_valid(vld2), .out_ready(out_ready), .out_data(dat2),
        .out_parity(par2), .out_count(cnt2), .out_sat(sat2));

    xor_stream_accum #(.WIDTH(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_a(in_a[0]), .in_b(in_b[0]),
        .in_last(in_last), .mode(mode), .out_valid(vld1), .out_ready(out_ready), .out_data(dat1),
        .out_parity(par1), .out_count(cnt1), .out_sat(sat1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cap(input int c, input int mx);
        return (c > mx) ? mx : c;
    endfunction

    // Model update on each rising edge from the inputs the bench is driving.
    initial forever begin : model
        bit       take;
        bit [7:0] x;
        @(posedge clk);
        if (rst) begin
            m_vld = 0; m_data = 0; m_cnt = 0; m_in_pkt = 0; m_acc = 0; m_pcnt = 0;
        end else begin
            take = in_valid && (!m_vld || out_ready);
            if (m_vld && out_ready) m_vld = 0;
            if (take) begin
                x = in_a ^ in_b;
                if (!m_in_pkt) begin
                    if (mode == 1'b0 || in_last) begin
                        m_data = x; m_cnt = 1; m_vld = 1;
                    end else begin
                        m_in_pkt = 1; m_acc = x; m_pcnt = 1;
                    end
                end else if (in_last) begin
                    m_data = m_acc ^ x; m_cnt = m_pcnt + 1; m_vld = 1;
                    m_in_pkt = 0; m_acc = 0; m_pcnt = 0;
                end else begin
                    m_acc = m_acc ^ x; m_pcnt = m_pcnt + 1;
                end
            end
        end
    end

    // Every-cycle comparison of all three instances against the model, away from the rising edge.
    initial forever begin : compare
        bit exp_rdy;
        @(negedge clk);
        if (chk_en) begin
            exp_rdy = !rst && (!m_vld || out_ready);
            chk("in_ready8", rdy8, exp_rdy);
            chk("in_ready2", rdy2, exp_rdy);
            chk("in_ready1", rdy1, exp_rdy);
            chk("out_valid8", vld8, m_vld);
            chk("out_valid2", vld2, m_vld);
            chk("out_valid1", vld1, m_vld);
            if (m_vld) begin
                chk("data8", dat8, m_data);
                chk("parity8", par8, ^m_data);
                chk("count8", cnt8, cap(m_cnt, 255));
                chk("sat8", sat8, m_cnt >= 255);
                chk("data2", dat2, m_data);
                chk("count2", cnt2, cap(m_cnt, 3));
                chk("sat2", sat2, m_cnt >= 3);
                chk("data1", dat1, m_data[0]);
                chk("parity1", par1, m_data[0]);
                chk("count1", cnt1, cap(m_cnt, 255));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until it is accepted; call at rising edge + 1.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic md, input logic lst);
        bit got = 1'b0;
        in_a = a; in_b = b; mode = md; in_last = lst; in_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = rdy8;
            @(posedge clk);
        end
        if (!got) chk("send_timeout", 32'd0, 32'd1);
        #1;
        in_valid = 1'b0;
    endtask

    logic exp1 [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; mode = 1'b0; out_ready = 1'b1;
        in_a = 8'h00; in_b = 8'h00;

        // Reset: in_ready low during reset, outputs cleared after it.
        @(negedge clk);
        chk("rst_in_ready", rdy8, 1'b0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", vld8, 1'b0);
        chk("rst_out_data", dat8, 8'h00);
        chk("rst_out_parity", par8, 1'b0);
        chk("rst_out_count", cnt8, 8'h00);
        chk("rst_out_sat", sat8, 1'b0);
        chk_en = 1'b1;
        step();

        // PASS single beat, one-cycle valid pulse.
        send(8'hF0, 8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        chk("pass_valid", vld8, 1'b1);
        chk("pass_data", dat8, 8'hCC);
        chk("pass_parity", par8, 1'b0);
        chk("pass_count", cnt8, 8'd1);
        step();
        @(negedge clk);
        chk("pass_valid_drop", vld8, 1'b0);
        step();

        // 1-bit exhaustive truth table.
        for (int i = 0; i < 4; i++) begin
            send(8'(i >> 1), 8'(i & 1), 1'b0, 1'b0);
            @(negedge clk);
            chk("xor1_data", dat1, exp1[i]);
            chk("xor1_parity", par1, exp1[i]);
            step();
        end

        // Three-beat ACCUM packet.
        send(8'h01, 8'h02, 1'b1, 1'b0);
        @(negedge clk);
        chk("acc_beat1_novalid", vld8, 1'b0);
        step();
        send(8'h04, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        chk("acc_beat2_novalid", vld8, 1'b0);
        step();
        send(8'h10, 8'h80, 1'b1, 1'b1);
        @(negedge clk);
        chk("acc_valid", vld8, 1'b1);
        chk("acc_data", dat8, 8'h97);
        chk("acc_parity", par8, 1'b1);
        chk("acc_count", cnt8, 8'd3);
        chk("acc_count_cnt2", cnt2, 2'd3);
        chk("acc_sat_cnt2", sat2, 1'b1);
        step();

        // Backpressure: hold result for 4 cycles, then release and accept together.
        out_ready = 1'b0;
        send(8'h5A, 8'h0F, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_hold_data", dat8, 8'h55);
            chk("bp_hold_valid", vld8, 1'b1);
            chk("bp_in_ready", rdy8, 1'b0);
            step();
        end
        out_ready = 1'b1;
        send(8'h33, 8'h11, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_nobubble_valid", vld8, 1'b1);
        chk("bp_new_data", dat8, 8'h22);
        step();

        // Saturation: five-beat packet.
        for (int i = 0; i < 5; i++) send(8'(i + 1), 8'h00, 1'b1, i == 4);
        @(negedge clk);
        chk("sat_data", dat8, 8'h01);
        chk("sat_count8", cnt8, 8'd5);
        chk("sat_count2", cnt2, 2'd3);
        chk("sat_flag2", sat2, 1'b1);
        chk("sat_flag8", sat8, 1'b0);
        step();

        // Mode dropped to PASS mid-packet is ignored.
        send(8'h11, 8'h00, 1'b1, 1'b0);
        send(8'h22, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("mode_mid_novalid", vld8, 1'b0);
        step();
        send(8'h44, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        chk("mode_mid_data", dat8, 8'h77);
        chk("mode_mid_count", cnt8, 8'd3);
        step();

        // Reset mid-packet discards the partial result.
        send(8'h0F, 8'h00, 1'b1, 1'b0);
        send(8'hF0, 8'h00, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", rdy8, 1'b0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_novalid", vld8, 1'b0);
        step();
        send(8'hAA, 8'h55, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_rst_data", dat8, 8'hFF);
        chk("post_rst_count", cnt8, 8'd1);
        step();
        send(8'h01, 8'h00, 1'b1, 1'b0);
        send(8'h02, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        chk("post_rst_acc_data", dat8, 8'h03);
        chk("post_rst_acc_count", cnt8, 8'd2);
        step();

        // Randomised traffic, stalls, mode/last mixes and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            mode      = 1'($urandom_range(0, 1));
            in_last   = ($urandom_range(0, 3) == 0);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            rst       = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/xor_stream_accum.md
Name: xor_stream_accum

Overview:
- Parametrised, registered successor to the single-bit XOR gate.
- WIDTH-bit bitwise XOR of two operand streams, with valid/ready handshaking.
- Two modes:
  - PASS: per-beat c = a ^ b.
  - ACCUM: running XOR across a packet delimited by in_last; one result per packet, with a parity bit and a beat count.
- Sits between data sources and checksum/parity consumers in the datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1)
- CNT_W, 8, width of the beat counter; counts saturate at 2**CNT_W-1

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_a  input  WIDTH  operand a
- in_b  input  WIDTH  operand b
- in_last  input  1  final beat of packet (ACCUM mode only; ignored in PASS)
- mode  input  1  0=PASS, 1=ACCUM; sampled only on the first beat of a packet
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  XOR result
- out_parity  output  1  reduction XOR of out_data
- out_count  output  CNT_W  beats contributing to out_data
- out_sat  output  1  out_count saturated

Behaviour:
- Reset: clk and rst are the only clock and reset; rst is synchronous, active-high. On reset:
  - FSM goes to IDLE, acc=0, cnt=0.
  - out_valid, out_data, out_parity, out_count and out_sat are all 0.
  - in_ready is 0 during the reset cycle.
- Accept and release rules:
  - Beat accepted when in_valid && in_ready.
  - Result released when out_valid && out_ready.
  - in_ready = !rst && (!out_valid || out_ready), combinational, with no dependence on in_valid.
- FSM: IDLE, ACCUM.
  - IDLE, accepted beat with mode=0: out_data <= a^b, out_count <= 1, out_valid <= 1 on the next edge (1-cycle latency). Stay in IDLE.
  - IDLE, accepted beat with mode=1 and in_last=1: single-beat packet. Same output as PASS; stay in IDLE.
  - IDLE, accepted beat with mode=1 and in_last=0: acc <= a^b, cnt <= 1, go to ACCUM. No output.
  - ACCUM, accepted beat with in_last=0: acc <= acc^a^b, cnt <= sat_inc(cnt). The mode input is ignored.
  - ACCUM, accepted beat with in_last=1: out_data <= acc^a^b, out_count <= sat_inc(cnt), out_valid <= 1, acc <= 0, cnt <= 0, go to IDLE.
- Output flags:
  - out_parity is registered together with out_data and equals ^out_data.
  - out_sat = (out_count == 2**CNT_W-1).
  - Counter saturates; no wrap.
- Output register:
  - Holds stable while out_valid && !out_ready.
  - out_valid clears after a release unless a new result loads in the same cycle.
- Simultaneous release and load: out_data updates, out_valid stays 1, no bubble. Full throughput is 1 beat/cycle in PASS mode.
- Non-last ACCUM beats are subject to the same in_ready gating (one rule, no bypass).
- Reset mid-packet discards acc and cnt; no partial result is emitted.
- Data is X-free: inputs are only sampled on acceptance.

Decomposition:
- Shared package xor_pkg: state enum (IDLE, ACCUM), MODE_PASS=1'b0, MODE_ACCUM=1'b1, and a sat_inc function generic in width.
- One sub-module: xor_out_reg. It owns the output register slice (data, parity, count, valid) and the in_ready equation.
- The top level holds the FSM, acc and cnt.

Test Plan:
- Reset then PASS, WIDTH=8: a=8'hF0, b=8'h3C, out_ready=1 -> next cycle out_data=8'hCC, out_parity=0, out_count=1, out_valid=1 for exactly 1 cycle.
- Exhaustive 1-bit equivalence at WIDTH=1, PASS: (0,0),(0,1),(1,0),(1,1) -> out_data 0,1,1,0; out_parity matches.
- ACCUM 3-beat packet: (8'h01,8'h02), (8'h04,8'h00), (8'h10,8'h80, last) -> single result out_data=8'h97, out_parity=1, out_count=3. No out_valid on beats 1-2.
- Backpressure: out_ready=0 for 4 cycles with a result pending -> out_data stable, in_ready=0. Raise out_ready while in_valid=1 -> release and accept in the same cycle, out_valid stays 1.
- Saturation, CNT_W=2: ACCUM packet of 5 beats -> out_count=3, out_sat=1.
- Mode ignored mid-packet, and reset mid-packet:
  - mode toggled to 0 during ACCUM -> still one packet result.
  - rst asserted after 2 ACCUM beats -> no output, acc cleared.
  - Next PASS beat (8'hAA,8'h55) -> out_data=8'hFF, out_count=1.
